// File: rtl/game_pkg.sv
// Shared state encoding, default timing/geometry parameters and colour helpers
// for the game screen controller.
package game_pkg;

  typedef enum logic [2:0] {
    StTitle   = 3'd0,
    StStart   = 3'd1,
    StPlaying = 3'd2,
    StPaused  = 3'd3,
    StWin     = 3'd4,
    StLose    = 3'd5
  } state_e;

  localparam int unsigned FramesTrocaDefault = 30;
  localparam int unsigned FimFramesDefault   = 180;
  localparam int unsigned HActiveDefault     = 640;
  localparam int unsigned VActiveDefault     = 480;

  // Dims a packed {R,G,B} pixel by halving each channel independently.
  function automatic logic [23:0] halve_rgb(input logic [23:0] rgb);
    return {1'b0, rgb[23:17], 1'b0, rgb[15:9], 1'b0, rgb[7:1]};
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame-start pulse generator and sprite animation phase (troca) counter.
module frame_timer
  import game_pkg::*;
#(
  parameter int unsigned FRAMES_TROCA = FramesTrocaDefault
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] h_counter,
  input  logic [9:0] v_counter,
  input  logic       freeze,
  output logic       frame_tick,
  output logic       troca
);

  localparam int unsigned CntW = (FRAMES_TROCA > 1) ? $clog2(FRAMES_TROCA) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FRAMES_TROCA - 1);

  logic            frame_tick_q;
  logic [CntW-1:0] troca_cnt_q, troca_cnt_d;
  logic            troca_q, troca_d;

  always_comb begin
    troca_cnt_d = troca_cnt_q;
    troca_d     = troca_q;
    if (frame_tick_q && !freeze) begin
      if (troca_cnt_q == CntMax) begin
        troca_cnt_d = '0;
        troca_d     = ~troca_q;
      end else begin
        troca_cnt_d = troca_cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_tick_q <= 1'b0;
      troca_cnt_q  <= '0;
      troca_q      <= 1'b0;
    end else begin
      frame_tick_q <= (h_counter == 10'd0) && (v_counter == 10'd0);
      troca_cnt_q  <= troca_cnt_d;
      troca_q      <= troca_d;
    end
  end

  assign frame_tick = frame_tick_q;
  assign troca      = troca_q;

endmodule

// File: rtl/game_screen_ctrl.sv
// Game screen sequencer: title/start/play/pause/win/lose flow, sprite reset and
// enable control, and registered selection of the displayed pixel layer.
module game_screen_ctrl
  import game_pkg::*;
#(
  parameter int unsigned FRAMES_TROCA = FramesTrocaDefault,
  parameter int unsigned FIM_FRAMES   = FimFramesDefault,
  parameter int unsigned H_ACTIVE     = HActiveDefault,
  parameter int unsigned V_ACTIVE     = VActiveDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  h_counter,
  input  logic [9:0]  v_counter,
  input  logic        btn_A,
  input  logic        btn_B,
  input  logic        vivo_jogador,
  input  logic        venceu,
  input  logic [23:0] rgb_tela,
  input  logic [23:0] rgb_jogo,
  input  logic [23:0] rgb_fim,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic        troca,
  output logic        jogo_reset,
  output logic        jogo_enable,
  output logic [2:0]  estado
);

  localparam int unsigned FimW = (FIM_FRAMES > 1) ? $clog2(FIM_FRAMES) : 1;
  localparam logic [FimW-1:0] FimMax = FimW'(FIM_FRAMES - 1);

  state_e          state_q, state_d;
  logic [FimW-1:0] fim_cnt_q, fim_cnt_d;
  logic            btn_a_q, btn_b_q, armed_q;
  logic            btn_a_edge, btn_b_edge;
  logic            frame_tick;
  logic            blank;
  logic [23:0]     rgb_d, rgb_q;

  frame_timer #(
    .FRAMES_TROCA(FRAMES_TROCA)
  ) u_frame_timer (
    .clk       (clk),
    .reset     (reset),
    .h_counter (h_counter),
    .v_counter (v_counter),
    .freeze    (state_q == StPaused),
    .frame_tick(frame_tick),
    .troca     (troca)
  );

  // armed_q masks the first cycle after reset so a held button is not seen as a press.
  assign btn_a_edge = armed_q & btn_A & ~btn_a_q;
  assign btn_b_edge = armed_q & btn_B & ~btn_b_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_a_q <= 1'b0;
      btn_b_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      btn_a_q <= btn_A;
      btn_b_q <= btn_B;
      armed_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StTitle;
      fim_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      fim_cnt_q <= fim_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    fim_cnt_d = '0;
    unique case (state_q)
      StTitle:   if (btn_a_edge) state_d = StStart;
      StStart:   if (frame_tick) state_d = StPlaying;
      StPlaying: begin
        if (!vivo_jogador)   state_d = StLose;
        else if (venceu)     state_d = StWin;
        else if (btn_b_edge) state_d = StPaused;
      end
      StPaused:  if (btn_b_edge) state_d = StPlaying;
      StWin, StLose: begin
        fim_cnt_d = fim_cnt_q;
        if (frame_tick) begin
          if (fim_cnt_q == FimMax) begin
            state_d   = StTitle;
            fim_cnt_d = '0;
          end else begin
            fim_cnt_d = fim_cnt_q + FimW'(1);
          end
        end
      end
      default:   state_d = StTitle;
    endcase
  end

  assign blank = (32'(h_counter) >= H_ACTIVE) || (32'(v_counter) >= V_ACTIVE);

  always_comb begin
    jogo_reset  = 1'b0;
    jogo_enable = 1'b0;
    rgb_d       = '0;
    unique case (state_q)
      StTitle, StStart: begin
        jogo_reset = 1'b1;
        rgb_d      = rgb_tela;
      end
      StPlaying: begin
        jogo_enable = 1'b1;
        rgb_d       = rgb_jogo;
      end
      StPaused:      rgb_d = halve_rgb(rgb_jogo);
      StWin, StLose: rgb_d = rgb_fim;
      default:       jogo_reset = 1'b1;
    endcase
    if (blank) rgb_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign R      = rgb_q[23:16];
  assign G      = rgb_q[15:8];
  assign B      = rgb_q[7:0];
  assign estado = state_q;

endmodule

// File: tb/tb_game_screen_ctrl.sv
// Directed bench for game_screen_ctrl: expectations are queued as stimulus is
// applied and checked against the outputs one cycle later.
module tb_game_screen_ctrl;

  logic        clk;
  logic        reset;
  logic [9:0]  h_counter, v_counter;
  logic        btn_A, btn_B, vivo_jogador, venceu;
  logic [23:0] rgb_tela, rgb_jogo, rgb_fim;
  logic [7:0]  R, G, B;
  logic        troca, jogo_reset, jogo_enable;
  logic [2:0]  estado;

  typedef enum int {SigEstado, SigRgb, SigTroca, SigJr, SigJe} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    logic [23:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   ticks    = 0;

  game_screen_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .h_counter   (h_counter),
    .v_counter   (v_counter),
    .btn_A       (btn_A),
    .btn_B       (btn_B),
    .vivo_jogador(vivo_jogador),
    .venceu      (venceu),
    .rgb_tela    (rgb_tela),
    .rgb_jogo    (rgb_jogo),
    .rgb_fim     (rgb_fim),
    .R           (R),
    .G           (G),
    .B           (B),
    .troca       (troca),
    .jogo_reset  (jogo_reset),
    .jogo_enable (jogo_enable),
    .estado      (estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [23:0] observe(input sig_e s);
    case (s)
      SigEstado: return {21'b0, estado};
      SigRgb:    return {R, G, B};
      SigTroca:  return {23'b0, troca};
      SigJr:     return {23'b0, jogo_reset};
      SigJe:     return {23'b0, jogo_enable};
      default:   return '0;
    endcase
  endfunction

  task automatic push(input string tag, input sig_e s, input logic [23:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic push_state(input string tag, input logic [2:0] est, input logic jr,
                            input logic je);
    push({tag, "_estado"}, SigEstado, {21'b0, est});
    push({tag, "_jogo_reset"}, SigJr, {23'b0, jr});
    push({tag, "_jogo_enable"}, SigJe, {23'b0, je});
  endtask

  task automatic push_troca(input string tag);
    push(tag, SigTroca, {23'b0, 1'(((ticks / 30) % 2))});
  endtask

  task automatic drain();
    exp_t        e;
    logic [23:0] got;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      got = observe(e.sig);
      checks++;
      assert (got === e.val) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, got, e.val);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame start at (0,0); counts toward the troca model unless paused.
  task automatic tick_frame(input bit counts);
    h_counter = 10'd0;
    v_counter = 10'd0;
    step(1);
    h_counter = 10'd5;
    v_counter = 10'd5;
    step(1);
    if (counts) ticks++;
  endtask

  initial begin
    reset        = 1'b1;
    h_counter    = 10'd5;
    v_counter    = 10'd5;
    btn_A        = 1'b0;
    btn_B        = 1'b0;
    vivo_jogador = 1'b1;
    venceu       = 1'b0;
    rgb_tela     = 24'h112233;
    rgb_jogo     = 24'h445566;
    rgb_fim      = 24'h778899;
    #1 reset = 1'b0;
    step(2);
    push_state("reset", 3'd0, 1'b1, 1'b0);
    push("reset_rgb", SigRgb, 24'h0);
    push_troca("reset_troca");
    drain();

    // Button held across reset release must not register as a press.
    btn_A = 1'b1;
    reset = 1'b1;
    step(3);
    push("held_a_title", SigEstado, 24'd0);
    drain();
    btn_A = 1'b0;
    step(1);
    push("released_a_title", SigEstado, 24'd0);
    drain();

    for (int i = 0; i < 10; i++) tick_frame(1);
    push("title_estado", SigEstado, 24'd0);
    push("title_rgb", SigRgb, 24'h112233);
    push_troca("title_troca");
    drain();

    btn_A = 1'b1;
    step(1);
    push_state("start", 3'd1, 1'b1, 1'b0);
    drain();
    btn_A = 1'b0;
    step(1);
    push("start_rgb", SigRgb, 24'h112233);
    drain();

    tick_frame(1);
    push_state("playing", 3'd2, 1'b0, 1'b1);
    drain();
    step(1);
    push("playing_rgb", SigRgb, 24'h445566);
    drain();

    for (int i = 0; i < 60; i++) begin
      tick_frame(1);
      push_troca("troca_run");
      drain();
    end
    push("run_estado", SigEstado, 24'd2);
    drain();

    btn_B = 1'b1;
    step(1);
    push_state("paused", 3'd3, 1'b0, 1'b0);
    drain();
    btn_B    = 1'b0;
    rgb_jogo = 24'hFF8040;
    step(1);
    push("paused_rgb", SigRgb, 24'h7F4020);
    drain();

    for (int i = 0; i < 40; i++) tick_frame(0);
    push_troca("paused_troca_frozen");
    push("paused_hold", SigEstado, 24'd3);
    drain();
    btn_A = 1'b1;
    step(1);
    btn_A = 1'b0;
    step(1);
    push("paused_ignores_a", SigEstado, 24'd3);
    drain();

    btn_A = 1'b1;
    btn_B = 1'b1;
    step(1);
    push("resume_ab", SigEstado, 24'd2);
    drain();
    btn_A = 1'b0;
    btn_B = 1'b0;
    step(1);
    push("resume_rgb", SigRgb, 24'hFF8040);
    drain();

    // Counter resumes where it froze: next toggle lands on the 90th counted tick.
    for (int i = 0; i < 19; i++) begin
      tick_frame(1);
      push_troca("troca_resume");
      drain();
    end

    h_counter = 10'd640;
    v_counter = 10'd100;
    step(1);
    push("blank_h", SigRgb, 24'h0);
    drain();
    h_counter = 10'd5;
    v_counter = 10'd480;
    step(1);
    push("blank_v", SigRgb, 24'h0);
    drain();
    h_counter = 10'd639;
    v_counter = 10'd479;
    step(1);
    push("edge_visible", SigRgb, 24'hFF8040);
    drain();
    h_counter = 10'd5;
    v_counter = 10'd5;

    vivo_jogador = 1'b0;
    venceu       = 1'b1;
    step(1);
    push_state("lose", 3'd5, 1'b0, 1'b0);
    drain();
    vivo_jogador = 1'b1;
    venceu       = 1'b0;
    step(1);
    push("lose_rgb", SigRgb, 24'h778899);
    drain();
    for (int i = 0; i < 179; i++) tick_frame(1);
    push("lose_hold_179", SigEstado, 24'd5);
    drain();
    tick_frame(1);
    push_state("lose_to_title", 3'd0, 1'b1, 1'b0);
    push_troca("lose_troca");
    drain();

    btn_A = 1'b1;
    step(1);
    btn_A = 1'b0;
    tick_frame(1);
    push("replay", SigEstado, 24'd2);
    drain();
    venceu = 1'b1;
    step(1);
    push_state("win", 3'd4, 1'b0, 1'b0);
    drain();
    venceu = 1'b0;

    // Asynchronous reset mid-game with A held.
    btn_A = 1'b1;
    #2 reset = 1'b0;
    #1;
    ticks = 0;
    push_state("async_reset", 3'd0, 1'b1, 1'b0);
    push("async_reset_rgb", SigRgb, 24'h0);
    push_troca("async_reset_troca");
    drain();
    step(2);
    reset = 1'b1;
    step(3);
    push("reset_held_a", SigEstado, 24'd0);
    drain();
    btn_A = 1'b0;
    step(1);
    btn_A = 1'b1;
    step(1);
    push("repress_a", SigEstado, 24'd1);
    drain();
    btn_A = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/game_screen_ctrl.md
GAME_SCREEN_CTRL -- requirements
Module: game_screen_ctrl

Interface
REQ-001 SHALL have parameter FRAMES_TROCA, default 30: frames between troca toggles.
REQ-002 SHALL have parameter FIM_FRAMES, default 180: frames WIN/LOSE screen is held.
REQ-003 SHALL have parameters H_ACTIVE, default 640, and V_ACTIVE, default 480: visible area.
REQ-004 SHALL have port clk  in  1  pixel clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports h_counter, v_counter  in  10  current VGA pixel coordinates.
REQ-007 SHALL have ports btn_A, btn_B  in  1  synchronized, active-high button levels (A = start, B = pause).
REQ-008 SHALL have ports vivo_jogador, venceu  in  1  player alive, all enemies destroyed.
REQ-009 SHALL have ports rgb_tela, rgb_jogo, rgb_fim  in  24  {R,G,B} of the title, game and end layers.
REQ-010 SHALL have ports R, G, B  out  8  composed pixel.
REQ-011 SHALL have port troca  out  1  sprite animation phase.
REQ-012 SHALL have port jogo_reset  out  1  active-high reset for game sprites.
REQ-013 SHALL have port jogo_enable  out  1  game logic may advance.
REQ-014 SHALL have port estado  out  3  current state encoding.

Function
REQ-015 SHALL generate frame_tick, a one-cycle pulse registered one cycle after h_counter==0 and v_counter==0.
REQ-016 SHALL edge-detect btn_A and btn_B with one registered stage each; only 0->1 transitions act.
REQ-017 SHALL implement states TITLE=0, START=1, PLAYING=2, PAUSED=3, WIN=4, LOSE=5.
REQ-018 TITLE SHALL go to START on btn_A edge.
REQ-019 START SHALL go to PLAYING on the next frame_tick.
REQ-020 PLAYING SHALL go to LOSE when vivo_jogador==0, else to WIN when venceu==1, else to PAUSED on btn_B edge; LOSE has priority over WIN, and both have priority over pause.
REQ-021 PAUSED SHALL return to PLAYING on btn_B edge; btn_A is ignored.
REQ-022 WIN and LOSE SHALL load frame counter fim_cnt with 0 on entry, increment it on each frame_tick, and go to TITLE on the frame_tick where fim_cnt==FIM_FRAMES-1.
REQ-023 SHALL set jogo_reset=1 in TITLE and START, else 0.
REQ-024 SHALL set jogo_enable=1 only in PLAYING.
REQ-025 SHALL run troca_cnt (width ceil(log2(FRAMES_TROCA))) on frame_tick in every state, and at troca_cnt==FRAMES_TROCA-1 SHALL wrap it to 0 and toggle troca.
REQ-026 SHALL freeze troca_cnt and troca in PAUSED.
REQ-027 SHALL register RGB with 1-cycle latency; source is rgb_tela in TITLE/START, rgb_jogo in PLAYING/PAUSED, rgb_fim in WIN/LOSE.
REQ-028 In PAUSED, SHALL output rgb_jogo with each channel halved (logical shift right 1).
REQ-029 SHALL output RGB 0 when h_counter>=H_ACTIVE or v_counter>=V_ACTIVE.
REQ-030 SHALL drive estado from the state register.
REQ-031 SHALL give simultaneous btn_A and btn_B edges no effect beyond REQ-018 to REQ-021.

Reset
REQ-032 With reset low, state SHALL be TITLE, all counters 0, edge registers 0, troca=0, R=G=B=0, jogo_reset=1, jogo_enable=0.
REQ-033 Reset asserted mid-game SHALL return to TITLE immediately, with no pending edge detected on release while the button is held.

Structure
REQ-034 State encodings and default parameter values SHALL reside in shared package game_pkg.
REQ-035 The frame-tick and troca counter logic SHALL be one sub-module, frame_timer.

Verification
REQ-036 After reset release, press btn_A -> START, then PLAYING at the next frame_tick; jogo_reset falls on entry to PLAYING.
REQ-037 In PLAYING, vivo_jogador=0 and venceu=1 in the same cycle -> LOSE (estado=5), RGB=rgb_fim, TITLE after 180 frame_ticks.
REQ-038 In PLAYING, btn_B edge -> PAUSED; rgb_jogo=24'hFF8040 gives RGB=7F,40,20; troca frozen; second btn_B -> PLAYING.
REQ-039 FRAMES_TROCA=30 -> troca toggles exactly every 30 frame_ticks across TITLE and PLAYING.
REQ-040 h_counter=640, v_counter=100 -> RGB=0 one cycle later regardless of state.
REQ-041 btn_A held through reset deassertion -> remains in TITLE until btn_A is released and pressed again.
